// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command queue: opcodes, command layout,
// controller states and the default queue depth.
package alu_pkg;

    localparam int DEFAULT_DEPTH = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_MAX  = OP_XNOR;

    // One queued command: 12 bits laid out as {op, a, b}.
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_MAX;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command storage for the ALU queue: a DEPTH-entry FIFO of {op,a,b} words
// with an occupancy counter. Pushes when full and pops when empty are ignored.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  cmd_t                     wdata,
    input  logic                     pop,
    output cmd_t                     rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for a push.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Command queue in front of a combinational ALU: buffers commands, issues one
// per ISSUE cycle, and holds each captured result until the consumer takes it.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic [3:0]               in_op,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [3:0]               alu_s,
    output logic                     alu_en,
    input  logic [7:0]               alu_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_y,
    output logic [3:0]               out_op,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    state_e     state_q, state_d;
    logic [7:0] out_y_q,   out_y_d;
    logic [3:0] out_op_q,  out_op_d;
    logic       out_err_q, out_err_d;

    cmd_t       in_cmd;
    cmd_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_acc;
    logic       issue;
    logic       work_avail;

    assign in_cmd   = '{op: in_op, a: in_a, b: in_b};
    assign in_ready = !fifo_full;
    assign push_acc = in_valid && in_ready;
    assign issue    = (state_q == ISSUE);

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (in_cmd),
        .pop   (issue),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    // A same-cycle push counts as work, so a command arriving while idle (or
    // while a result is being taken) issues on the very next cycle.
    assign work_avail = !fifo_empty || push_acc;

    always_comb begin
        state_d   = state_q;
        out_y_d   = out_y_q;
        out_op_d  = out_op_q;
        out_err_d = out_err_q;
        case (state_q)
            IDLE: begin
                if (work_avail) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                out_y_d   = alu_y;
                out_op_d  = head.op;
                out_err_d = op_illegal(head.op);
                state_d   = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = work_avail ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_y_q   <= '0;
            out_op_q  <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_y_q   <= out_y_d;
            out_op_q  <= out_op_d;
            out_err_q <= out_err_d;
        end
    end

    assign alu_en    = issue;
    assign alu_a     = issue ? head.a  : 4'd0;
    assign alu_b     = issue ? head.b  : 4'd0;
    assign alu_s     = issue ? head.op : 4'd0;

    assign out_valid = (state_q == HOLD);
    assign out_y     = out_y_q;
    assign out_op    = out_op_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with a behavioural downstream ALU.
module tb_alu_cmd_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0, in_b = '0, in_op = '0;
    logic [3:0] alu_a, alu_b, alu_s;
    logic       alu_en;
    logic [7:0] alu_y;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_y;
    logic [3:0] out_op;
    logic       out_err;
    logic [2:0] count;

    int n_pass  = 0;
    int n_total = 0;

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_en    (alu_en),
        .alu_y     (alu_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_op    (out_op),
        .out_err   (out_err),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Downstream combinational ALU; illegal opcodes return 0.
    always_comb begin
        alu_y = 8'd0;
        case (alu_s)
            OP_ADD:  alu_y = {4'd0, alu_a} + {4'd0, alu_b};
            OP_SUB:  alu_y = {4'd0, alu_a} - {4'd0, alu_b};
            OP_MUL:  alu_y = {4'd0, alu_a} * {4'd0, alu_b};
            OP_AND:  alu_y = {4'd0, alu_a & alu_b};
            OP_OR:   alu_y = {4'd0, alu_a | alu_b};
            OP_XOR:  alu_y = {4'd0, alu_a ^ alu_b};
            OP_SHL:  alu_y = {4'd0, alu_a} << alu_b;
            OP_SHR:  alu_y = {4'd0, alu_a} >> alu_b;
            OP_NAND: alu_y = {4'd0, ~(alu_a & alu_b)};
            OP_XNOR: alu_y = {4'd0, ~(alu_a ^ alu_b)};
            default: alu_y = 8'd0;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else n_pass++;
        n_total++; if (out_y !== 8'd0) $display("FAIL rst_out_y got=%0h exp=0", out_y); else n_pass++;
        n_total++; if (out_op !== 4'd0 || out_err !== 1'b0) $display("FAIL rst_out_op_err got=%0d/%0b exp=0/0", out_op, out_err); else n_pass++;
        n_total++; if (alu_en !== 1'b0 || alu_a !== 4'd0) $display("FAIL rst_alu got en=%0b a=%0d exp=0/0", alu_en, alu_a); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", count); else n_pass++;
        step();
        step();
        rst_n = 1'b1;
        step();
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%0b exp=1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_release_valid got=%0b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(OP_ADD, 4'd15, 4'd15);
        n_total++; if (in_ready !== 1'b1) $display("FAIL single_in_ready got=%0b exp=1", in_ready); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++;
        if (alu_en !== 1'b1 || alu_a !== 4'd15 || alu_b !== 4'd15 || alu_s !== 4'd0 || out_valid !== 1'b0)
            $display("FAIL single_issue got en=%0b a=%0d b=%0d s=%0d v=%0b exp 1/15/15/0/0", alu_en, alu_a, alu_b, alu_s, out_valid);
        else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%0b exp=1", out_valid); else n_pass++;
        n_total++; if (out_y !== 8'd30) $display("FAIL single_y got=%0d exp=30", out_y); else n_pass++;
        n_total++; if (out_op !== 4'd0 || out_err !== 1'b0) $display("FAIL single_op_err got=%0d/%0b exp=0/0", out_op, out_err); else n_pass++;
        n_total++; if (alu_en !== 1'b0 || alu_a !== 4'd0 || alu_s !== 4'd0) $display("FAIL hold_alu_zero got en=%0b a=%0d s=%0d exp=0", alu_en, alu_a, alu_s); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL single_done got v=%0b cnt=%0d exp=0/0", out_valid, count); else n_pass++;
    endtask

    task automatic test_order();
        out_ready = 1'b1;
        drive(OP_SUB, 4'd3, 4'd5);
        step();
        drive(OP_MUL, 4'd15, 4'd15);
        step();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1 || out_y !== 8'hFE) $display("FAIL order_first got v=%0b y=%0h exp=1/fe", out_valid, out_y); else n_pass++;
        n_total++; if (out_op !== 4'd1) $display("FAIL order_first_op got=%0d exp=1", out_op); else n_pass++;
        step();
        n_total++; if (alu_en !== 1'b1 || alu_s !== 4'd2) $display("FAIL order_issue2 got en=%0b s=%0d exp=1/2", alu_en, alu_s); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b1 || out_y !== 8'hE1) $display("FAIL order_second got v=%0b y=%0h exp=1/e1", out_valid, out_y); else n_pass++;
        step();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(OP_ADD, 4'(i), 4'd1);
            if (in_ready === 1'b1) acc++;
            step();
        end
        drive(OP_ADD, 4'd9, 4'd9);
        n_total++; if (acc !== 5) $display("FAIL bp_accepted got=%0d exp=5", acc); else n_pass++;
        n_total++; if (in_ready !== 1'b0 || count !== 3'd4) $display("FAIL bp_full got rdy=%0b cnt=%0d exp=0/4", in_ready, count); else n_pass++;
        n_total++; if (out_valid !== 1'b1 || out_y !== 8'd1) $display("FAIL bp_held got v=%0b y=%0d exp=1/1", out_valid, out_y); else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++; if (in_ready !== 1'b0 || alu_a !== 4'd1) $display("FAIL bp_full_pop got rdy=%0b a=%0d exp=0/1", in_ready, alu_a); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (count !== 3'd3 || out_y !== 8'd2) $display("FAIL bp_refused got cnt=%0d y=%0d exp=3/2", count, out_y); else n_pass++;
        for (int j = 3; j <= 5; j++) begin
            step();
            step();
            n_total++;
            if (out_valid !== 1'b1 || out_y !== 8'(j)) $display("FAIL bp_result got v=%0b y=%0d exp=1/%0d", out_valid, out_y, j);
            else n_pass++;
        end
        step();
        step();
        n_total++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL bp_drained got cnt=%0d v=%0b exp=0/0", count, out_valid); else n_pass++;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(4'd12, 4'd7, 4'd7);
        step();
        in_valid = 1'b0;
        n_total++; if (alu_en !== 1'b1 || alu_s !== 4'd12) $display("FAIL illegal_issue got en=%0b s=%0d exp=1/12", alu_en, alu_s); else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b1 || out_y !== 8'd0 || out_err !== 1'b1 || out_op !== 4'd12)
            $display("FAIL illegal_result got v=%0b y=%0d err=%0b op=%0d exp=1/0/1/12", out_valid, out_y, out_err, out_op);
        else n_pass++;
        step();
    endtask

    task automatic test_push_in_hold();
        out_ready = 1'b0;
        drive(OP_OR, 4'd5, 4'd10);
        step();
        in_valid = 1'b0;
        step();
        step();
        n_total++; if (out_valid !== 1'b1 || out_y !== 8'd15) $display("FAIL hold_stable got v=%0b y=%0d exp=1/15", out_valid, out_y); else n_pass++;
        out_ready = 1'b1;
        drive(OP_SUB, 4'd9, 4'd4);
        step();
        in_valid = 1'b0;
        n_total++;
        if (alu_en !== 1'b1 || alu_a !== 4'd9 || out_valid !== 1'b0)
            $display("FAIL hold_push_issue got en=%0b a=%0d v=%0b exp=1/9/0", alu_en, alu_a, out_valid);
        else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b1 || out_y !== 8'd5 || out_op !== 4'd1) $display("FAIL hold_push_result got v=%0b y=%0d op=%0d exp=1/5/1", out_valid, out_y, out_op); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(OP_ADD, 4'(i), 4'd2);
            step();
        end
        in_valid = 1'b0;
        n_total++; if (count !== 3'd3 || out_valid !== 1'b1) $display("FAIL mid_pre got cnt=%0d v=%0b exp=3/1", count, out_valid); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL mid_reset got v=%0b cnt=%0d exp=0/0", out_valid, count); else n_pass++;
        n_total++; if (out_y !== 8'd0 || alu_en !== 1'b0) $display("FAIL mid_reset_data got y=%0d en=%0b exp=0/0", out_y, alu_en); else n_pass++;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (out_valid !== 1'b0 || alu_en !== 1'b0) seen++;
            step();
        end
        n_total++; if (seen !== 0) $display("FAIL mid_no_output got=%0d exp=0", seen); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL mid_in_ready got=%0b exp=1", in_ready); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_backpressure();
        test_illegal();
        test_push_in_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
